dff_bank_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared WIDTH-bit D-flip-flop register bank. Up to NREQ requesters compete for it. The block grants one requester at a time and loads that requester's data into the bank. It holds the value stable for a fixed number of cycles so the consumer can sample it, then signals completion and moves on to the next requester. It sits between the requester datapaths and the shared storage register, and it owns that register.

---
 rtl/dff_bank_arbiter.sv | 141 ++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
// Round-robin arbiter and sequencer that owns a shared WIDTH-bit register.
// One requester is granted at a time. Its data is loaded into q and held
// stable for HOLD cycles. A one-cycle done pulse then flags completion, and
// the rotating priority pointer moves past the requester just served.
//
// Ports:
//   clk      system clock, rising-edge
//   rst      synchronous active-high reset
//   req      per-requester level request (bit i = requester i)
//   din      requester data, requester i at din[i*WIDTH +: WIDTH]
//   gnt      registered one-hot grant, zero when idle
//   q        shared register contents
//   q_valid  high while q holds a granted value
//   q_owner  index of current / most recent grantee
//   done     one-hot single-cycle completion pulse
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no transfer in progress; arbitrate among req each cycle
// S_HOLD | q loaded for q_owner; cnt counts down remaining hold cycles
module dff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [2:0]            q_owner,
  output logic [NREQ-1:0]       done
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [NREQ-1:0]   gnt_nxt, done_nxt;
  logic [WIDTH-1:0]  q_nxt;
  logic              q_valid_nxt;
  logic [2:0]        q_owner_nxt;

  logic [2:0]        win;
  logic              win_found;
  logic [WIDTH-1:0]  win_data;

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
    logic [NREQ-1:0] oh;
    for (int i = 0; i < NREQ; i++) oh[i] = (idx == 3'(i));
    return oh;
  endfunction

  // Search from ptr upward with wrap. Offsets are scanned from the far end
  // back toward ptr so the smallest offset with a request is the last hit.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          win       = 3'(i);
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) win_data = din[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt;
    q_nxt       = q;
    q_valid_nxt = q_valid;
    q_owner_nxt = q_owner;
    done_nxt    = '0;
    case (state)
      S_IDLE: begin
        gnt_nxt     = '0;
        q_valid_nxt = 1'b0;
        if (win_found) begin
          q_nxt       = win_data;
          q_owner_nxt = win;
          gnt_nxt     = onehot(win);
          q_valid_nxt = 1'b1;
          cnt_nxt     = CW'(HOLD - 1);
          state_nxt   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          gnt_nxt     = '0;
          q_valid_nxt = 1'b0;
          done_nxt    = onehot(q_owner);
          ptr_nxt     = (q_owner == 3'(NREQ - 1)) ? 3'd0 : q_owner + 3'd1;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      q_owner <= '0;
      done    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      q       <= q_nxt;
      q_valid <= q_valid_nxt;
      q_owner <= q_owner_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Testbench for dff_bank_arbiter: directed scenarios followed by random
// traffic. A transaction-level model predicts each grant (who, what data,
// at which edge) and queues it; a monitor on the falling edge checks the
// DUT's grant window, hold length, done pulse and reset behaviour.
module tb_dff_bank_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int HOLD  = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic [2:0]            q_owner;
  logic [NREQ-1:0]       done;

  dff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .q(q),
    .q_valid(q_valid), .q_owner(q_owner), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         owner;
    logic [7:0] data;
    int         edge_no;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rst_edge = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: the bank is free again HOLD+1 edges after a grant;
  // the winner is the first requester at or after ptr, wrapping.
  int m_ptr = 0;
  int m_free = 0;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        rst_edge = 1'b1;
        m_ptr    = 0;
        m_free   = cyc + 1;
      end else begin
        rst_edge = 1'b0;
        if (cyc >= m_free && req != '0) begin
          txn_t t;
          int   w;
          w = -1;
          for (int k = 0; k < NREQ && w < 0; k++) begin
            if (req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
          end
          t.owner   = w;
          t.data    = din[w*WIDTH +: WIDTH];
          t.edge_no = cyc;
          sb.push_back(t);
          m_ptr  = (w + 1) % NREQ;
          m_free = cyc + HOLD + 1;
        end
      end
    end
  end

  // Monitor
  txn_t       cur;
  bit         active = 1'b0;
  int         hold_seen = 0;
  logic [7:0] last_q = '0;
  int         last_owner = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_q_valid", int'(q_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q_owner", int'(q_owner), 0);
        active = 1'b0; hold_seen = 0; last_q = '0; last_owner = 0;
        sb.delete();
      end else if (done != '0) begin
        chk("done_while_active", int'(active), 1);
        chk("done_onehot", int'(done), 1 << cur.owner);
        chk("hold_len", hold_seen, HOLD);
        chk("done_gnt_low", int'(gnt), 0);
        chk("done_q_valid_low", int'(q_valid), 0);
        chk("done_q_kept", int'(q), int'(last_q));
        active = 1'b0;
      end else if (q_valid) begin
        if (!active) begin
          chk("grant_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("grant_edge", cyc, cur.edge_no);
            chk("grant_gnt", int'(gnt), 1 << cur.owner);
            chk("grant_q", int'(q), int'(cur.data));
            chk("grant_owner", int'(q_owner), cur.owner);
            active = 1'b1; hold_seen = 1;
            last_q = cur.data; last_owner = cur.owner;
          end
        end else begin
          hold_seen++;
          chk("hold_not_too_long", int'(hold_seen <= HOLD), 1);
          chk("hold_q", int'(q), int'(cur.data));
          chk("hold_gnt", int'(gnt), 1 << cur.owner);
          chk("hold_owner", int'(q_owner), cur.owner);
        end
      end else begin
        chk("idle_gnt", int'(gnt), 0);
        chk("missing_done", int'(active), 0);
        chk("missed_grant", sb.size(), 0);
        chk("idle_q_kept", int'(q), int'(last_q));
        chk("idle_owner_kept", int'(q_owner), last_owner);
        active = 1'b0;
      end
    end
  end

  task automatic set_din(input int i, input logic [7:0] v);
    din[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic wait_gnt(input int b);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (gnt[b]) break;
    end
    chk("wait_gnt", int'(gnt[b]), 1);
  endtask

  initial begin
    rst = 1'b1;
    req = '1;
    din = '0;
    for (int i = 0; i < NREQ; i++) set_din(i, 8'h10 + 8'(i));
    repeat (2) @(negedge clk);

    // Single requester, held
    rst = 1'b0;
    req = 4'b0100;
    set_din(2, 8'hA5);
    repeat (8) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // Fairness from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_din(i, 8'h10 + 8'(i));
    repeat (15) @(negedge clk);

    // Wrap priority: wait for requester 3, then 0 and 3 compete
    wait_gnt(3);
    req = 4'b1001;
    repeat (9) @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);

    // Mid-hold changes are ignored
    req = 4'b0010;
    set_din(1, 8'h3C);
    wait_gnt(1);
    req = '0;
    set_din(1, 8'hFF);
    repeat (4) @(negedge clk);

    // Reset in the first hold cycle
    req = 4'b0100;
    wait_gnt(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    repeat (8) @(negedge clk);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      else if ($urandom_range(0, 5) == 0) req = '0;
      din = (NREQ*WIDTH)'($urandom);
      @(negedge clk);
    end

    rst = 1'b0;
    req = '0;
    repeat (HOLD + 4) @(negedge clk);
    chk("end_queue_empty", sb.size(), 0);
    chk("end_inactive", int'(active), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
